// File: rtl/fir_capture_ram_pkg.sv
// Shared definitions for the FIR output capture buffer: FSM state encoding
// and the capture-length helper.
package fir_capture_ram_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ARMED   = ST_ARMED,
      CAPTURE = ST_CAPTURE,
      DONE    = ST_DONE
   } cap_state_e;

   // Number of samples in one full capture for a given address width.
   function automatic int unsigned capture_len(input int unsigned nb_depth);
      return 32'd1 << nb_depth;
   endfunction

endpackage

// File: rtl/fir_capture_ram_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port,
// no reset so that it maps onto block RAM.
module capture_dpram #(
   parameter int NB_DATA = 21,
   parameter int NB_ADDR = 14
) (
   input  logic               i_clk,
   input  logic               i_wr_en,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [NB_DATA-1:0] i_wr_data,
   input  logic               i_rd_en,
   input  logic [NB_ADDR-1:0] i_rd_addr,
   output logic [NB_DATA-1:0] o_rd_data
);

   logic [NB_DATA-1:0] mem_r [0:(2**NB_ADDR)-1];
   logic [NB_DATA-1:0] rd_data_r;

   // Write port.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_r[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read port; holds its value between requests.
   always_ff @(posedge i_clk) begin
      if (i_rd_en) begin
         rd_data_r <= mem_r[i_rd_addr];
      end
   end

   assign o_rd_data = rd_data_r;

endmodule

// File: rtl/fir_capture_ram.sv
// Arm/trigger capture buffer for filter output samples with a one-cycle
// registered random-access read port for readout.
module fir_capture_ram
   import fir_capture_ram_pkg::*;
#(
   parameter int NB_DATA  = 21,
   parameter int NB_DEPTH = 14
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_arm,
   input  logic                i_trigger,
   input  logic                i_valid,
   input  logic [NB_DATA-1:0]  i_data,
   input  logic                i_rd_en,
   input  logic [NB_DEPTH-1:0] i_rd_addr,
   output logic [NB_DATA-1:0]  o_rd_data,
   output logic                o_rd_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic [NB_DEPTH:0]   o_wr_count
);

   localparam logic [NB_DEPTH:0] CAP_LEN  = (NB_DEPTH+1)'(capture_len(NB_DEPTH));
   localparam logic [NB_DEPTH:0] CNT_ZERO = {(NB_DEPTH+1){1'b0}};
   localparam logic [NB_DEPTH:0] CNT_ONE  = {{NB_DEPTH{1'b0}}, 1'b1};

   cap_state_e         state_r, state_s;
   logic [NB_DEPTH:0]  count_r, count_s, count_inc_s;
   logic               wr_en_s, rd_hit_s;
   logic               busy_r, done_r, rd_valid_r, rd_loaded_r;
   logic [NB_DATA-1:0] ram_q_s;

   assign count_inc_s = count_r + CNT_ONE;
   // Read and write ports are never active in the same state.
   assign rd_hit_s    = i_rd_en && ((state_r == IDLE) || (state_r == DONE));

   // Next-state, write enable and sample counter.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      wr_en_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (i_arm) begin
               state_s = ARMED;
               count_s = CNT_ZERO;
            end else begin
               state_s = state_r;
            end
         end
         ARMED: begin
            if (i_trigger) begin
               state_s = CAPTURE;
               wr_en_s = i_valid;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         CAPTURE: wr_en_s = i_valid;
         default: state_s = IDLE;
      endcase
      // The write that fills the buffer finishes the capture on the same edge.
      if (wr_en_s) begin
         count_s = count_inc_s;
         state_s = (count_inc_s == CAP_LEN) ? DONE : state_s;
      end else begin
         count_s = count_s;
      end
   end

   // State, counter and registered status/read-valid outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= IDLE;
         count_r     <= CNT_ZERO;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rd_valid_r  <= 1'b0;
         rd_loaded_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         count_r     <= count_s;
         busy_r      <= (state_s == ARMED) || (state_s == CAPTURE);
         done_r      <= (state_s == DONE);
         rd_valid_r  <= rd_hit_s;
         rd_loaded_r <= rd_loaded_r | rd_hit_s;
      end
   end

   capture_dpram #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_DEPTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (wr_en_s),
      .i_wr_addr (count_r[NB_DEPTH-1:0]),
      .i_wr_data (i_data),
      .i_rd_en   (rd_hit_s),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (ram_q_s)
   );

   // The RAM read register has no reset, so its output is masked to zero
   // until the first read after reset has loaded it.
   assign o_rd_data  = rd_loaded_r ? ram_q_s : {NB_DATA{1'b0}};
   assign o_rd_valid = rd_valid_r;
   assign o_busy     = busy_r;
   assign o_done     = done_r;
   assign o_wr_count = count_r;

endmodule

// File: tb/tb_fir_capture_ram.sv
// Self-checking bench for fir_capture_ram with a 16-word buffer.
module tb_fir_capture_ram;

   localparam int NB_DATA  = 21;
   localparam int NB_DEPTH = 4;
   localparam int LEN      = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                arm = 1'b0, trigger = 1'b0, valid = 1'b0, rd_en = 1'b0;
   logic [NB_DATA-1:0]  data = '0;
   logic [NB_DEPTH-1:0] rd_addr = '0;
   logic [NB_DATA-1:0]  rd_data;
   logic                rd_valid, busy, done;
   logic [NB_DEPTH:0]   wr_count;

   int total = 0;
   int bad   = 0;
   logic [NB_DATA-1:0] mdl_mem [LEN];

   fir_capture_ram #(.NB_DATA(NB_DATA), .NB_DEPTH(NB_DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_trigger(trigger),
      .i_valid(valid), .i_data(data), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy),
      .o_done(done), .o_wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      arm = 0; trigger = 0; valid = 0; rd_en = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
      total++; if (wr_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", wr_count); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
      total++; if (rd_data !== 21'd0) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
   endtask

   task automatic test_basic;
      int a;
      arm = 1; step(); arm = 0;
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL basic_armed: got busy/done %b want 10", {busy, done}); end
      for (int k = 0; k < LEN; k++) begin
         trigger = (k == 0); valid = 1; data = NB_DATA'(k);
         mdl_mem[k] = NB_DATA'(k);
         step();
         total++; if (wr_count !== 5'(k + 1)) begin bad++; $display("FAIL basic_count: got %0d want %0d", wr_count, k + 1); end
         total++; if (done !== (k == LEN - 1)) begin bad++; $display("FAIL basic_done: k=%0d got %0b want %0b", k, done, k == LEN - 1); end
      end
      idle_inputs();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %0b want 0", busy); end
      rd_en = 1; rd_addr = 4'd5; step(); rd_en = 0;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_rd_valid: got %0b want 1", rd_valid); end
      total++; if (rd_data !== 21'd5) begin bad++; $display("FAIL basic_rd5: got %0h want 5", rd_data); end
      step();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_rd_idle: got %0b want 0", rd_valid); end
      total++; if (rd_data !== 21'd5) begin bad++; $display("FAIL basic_rd_hold: got %0h want 5", rd_data); end
      // Back-to-back random-address reads.
      for (int i = 0; i < 20; i++) begin
         a = $urandom_range(0, LEN - 1);
         rd_en = 1; rd_addr = 4'(a); step();
         total++; if (rd_valid !== 1'b1 || rd_data !== mdl_mem[a]) begin
            bad++; $display("FAIL basic_b2b: addr %0d got v=%0b d=%0h want v=1 d=%0h", a, rd_valid, rd_data, mdl_mem[a]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_gapped;
      logic [NB_DATA-1:0] q[$];
      bit started;
      int done_at, a;
      arm = 1; step(); arm = 0;
      started = 0; done_at = -1;
      for (int c = 0; c < 44; c++) begin
         trigger = (c == 0);
         valid = (q.size() < LEN) ? c[0] : 1'b1;
         data = NB_DATA'($urandom);
         rd_en = (q.size() < LEN) && ($urandom_range(0, 1) == 1);
         rd_addr = 4'($urandom_range(0, LEN - 1));
         if (trigger) started = 1;
         if (started && valid && q.size() < LEN) q.push_back(data);
         step();
         total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL gap_rd_blocked: c=%0d got %0b want 0", c, rd_valid); end
         total++; if (wr_count !== 5'(q.size())) begin bad++; $display("FAIL gap_count: c=%0d got %0d want %0d", c, wr_count, q.size()); end
         total++; if (done !== (q.size() == LEN)) begin bad++; $display("FAIL gap_done: c=%0d got %0b want %0b", c, done, q.size() == LEN); end
         if (done === 1'b1 && done_at < 0) done_at = c + 1;
      end
      idle_inputs();
      total++; if (done_at !== 32) begin bad++; $display("FAIL gap_done_cycle: got %0d want 32", done_at); end
      for (int i = 0; i < LEN; i++) mdl_mem[i] = q[i];
      rd_en = 1; rd_addr = 4'd0; step();
      total++; if (rd_data !== q[0]) begin bad++; $display("FAIL gap_addr0: got %0h want %0h", rd_data, q[0]); end
      for (int i = 0; i < LEN; i++) begin
         a = $urandom_range(0, LEN - 1);
         rd_addr = 4'(a); step();
         total++; if (rd_valid !== 1'b1 || rd_data !== mdl_mem[a]) begin
            bad++; $display("FAIL gap_readback: addr %0d got v=%0b d=%0h want v=1 d=%0h", a, rd_valid, rd_data, mdl_mem[a]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid;
      int a;
      arm = 1; step(); arm = 0;
      for (int k = 0; k < 7; k++) begin
         trigger = (k == 0); valid = 1; data = NB_DATA'($urandom);
         step();
      end
      idle_inputs();
      total++; if (wr_count !== 5'd7) begin bad++; $display("FAIL mid_count7: got %0d want 7", wr_count); end
      #2 rst_n = 0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
      total++; if (wr_count !== 5'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", wr_count); end
      total++; if (done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mid_flags: got done=%0b v=%0b want 0 0", done, rd_valid); end
      step();
      rst_n = 1;
      arm = 1; step(); arm = 0;
      for (int k = 0; k < LEN; k++) begin
         trigger = (k == 0); valid = 1; data = {NB_DATA{1'b1}};
         mdl_mem[k] = {NB_DATA{1'b1}};
         step();
      end
      idle_inputs();
      total++; if (done !== 1'b1 || wr_count !== 5'd16) begin bad++; $display("FAIL mid_recapture: got done=%0b cnt=%0d want 1 16", done, wr_count); end
      for (int i = 0; i < 6; i++) begin
         a = $urandom_range(0, LEN - 1);
         rd_en = 1; rd_addr = 4'(a); step();
         total++; if (rd_data !== 21'h1FFFFF) begin bad++; $display("FAIL mid_ones: addr %0d got %0h want 1fffff", a, rd_data); end
      end
      idle_inputs();
   endtask

   task automatic test_simultaneous;
      int a;
      logic [NB_DATA-1:0] d0;
      a = $urandom_range(0, LEN - 1);
      arm = 1; rd_en = 1; rd_addr = 4'(a); step(); idle_inputs();
      total++; if (rd_valid !== 1'b1 || rd_data !== mdl_mem[a]) begin
         bad++; $display("FAIL sim_arm_read: got v=%0b d=%0h want v=1 d=%0h", rd_valid, rd_data, mdl_mem[a]);
      end
      total++; if ({busy, done} !== 2'b10 || wr_count !== 5'd0) begin
         bad++; $display("FAIL sim_arm_state: got busy/done=%b cnt=%0d want 10 0", {busy, done}, wr_count);
      end
      do_reset();
      arm = 1; trigger = 1; valid = 1; data = 21'h12345; step();
      total++; if (busy !== 1'b1 || wr_count !== 5'd0) begin bad++; $display("FAIL sim_arm_trig: got busy=%0b cnt=%0d want 1 0", busy, wr_count); end
      arm = 0; trigger = 0; valid = 1; data = 21'h0BEEF; step();
      total++; if (wr_count !== 5'd0 || busy !== 1'b1) begin bad++; $display("FAIL sim_armed_wait: got busy=%0b cnt=%0d want 1 0", busy, wr_count); end
      d0 = 21'h0ABCD;
      for (int k = 0; k < LEN; k++) begin
         trigger = (k == 0); valid = 1;
         data = (k == 0) ? d0 : NB_DATA'($urandom);
         mdl_mem[k] = data;
         step();
      end
      idle_inputs();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL sim_done: got %0b want 1", done); end
      rd_en = 1; rd_addr = 4'd0; step(); rd_en = 0;
      total++; if (rd_data !== d0) begin bad++; $display("FAIL sim_addr0: got %0h want %0h", rd_data, d0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_reset_mid();
      test_simultaneous();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
